// File: rtl/crc8_pkg.sv
// Shared CRC-8 constants, FSM state type and bit-serial CRC step, used by both TX and RX sides.
package crc8_pkg;

    localparam logic [7:0] CRC8_POLY = 8'h07;
    localparam logic [7:0] CRC8_INIT = 8'h00;
    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        CRC,
        GAP
    } crc8_state_e;

    // One MSB-first bit through the CRC-8 shift register.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic fb;
        fb = crc[7] ^ b;
        return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_bit_timer.sv
// Bit-period divider: tick_o pulses on the last clock of every CLKS_PER_BIT-clock bit period.
module crc8_bit_timer #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    output logic tick_o
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] CNT_LAST = TW'(CLKS_PER_BIT - 1);

    logic [TW-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == CNT_LAST);

    // Held at zero while disabled so the first period after IDLE is full length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!en_i || tick_o) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

endmodule

// File: rtl/crc8_serial_tx.sv
// Serial CRC-8 frame transmitter: payload bytes MSB-first followed by the CRC byte, then an idle gap.
// Define CRC8_TX_SYNC_EN to prefix every frame with the sync byte (not covered by the CRC).
module crc8_serial_tx
    import crc8_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1,
    parameter int GAP_BITS     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       tx_bit,
    output logic       tx_active,
    output logic       frame_done,
    output logic       underrun
);

    localparam int GW = $clog2(GAP_BITS + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_BITS - 1);

    crc8_state_e   state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    hold_q;
    logic          hold_vld_q;
    logic          last_seen_q;
    logic [7:0]    crc_q;
    logic [GW-1:0] gapcnt_q;
    logic          tx_bit_q, tx_active_q, frame_done_q, underrun_q;

    logic tick, accept, bnd;

    crc8_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (state_q != IDLE),
        .tick_o (tick)
    );

    always_comb begin
        s_ready = 1'b0;
        case (state_q)
            IDLE: s_ready = 1'b1;
`ifdef CRC8_TX_SYNC_EN
            SYNC,
`endif
            DATA: s_ready = !hold_vld_q && !last_seen_q;
            default: s_ready = 1'b0;
        endcase
    end

    assign accept = s_valid && s_ready;
    assign bnd    = tick && (bitcnt_q == 3'd7);

    assign tx_bit     = tx_bit_q;
    assign tx_active  = tx_active_q;
    assign frame_done = frame_done_q;
    assign underrun   = underrun_q;

    // shift_q holds the bits still to send after the one currently on tx_bit_q.
    // crc_q is advanced when a payload bit goes onto the line, so at a byte
    // boundary it already covers every payload bit sent.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            shift_q      <= '0;
            bitcnt_q     <= '0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            last_seen_q  <= 1'b0;
            crc_q        <= CRC8_INIT;
            gapcnt_q     <= '0;
            tx_bit_q     <= 1'b0;
            tx_active_q  <= 1'b0;
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            underrun_q   <= 1'b0;
            if (accept && s_last) last_seen_q <= 1'b1;

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        last_seen_q <= s_last;
                        bitcnt_q    <= '0;
                        tx_active_q <= 1'b1;
`ifdef CRC8_TX_SYNC_EN
                        state_q     <= SYNC;
                        shift_q     <= {SYNC_BYTE[6:0], 1'b0};
                        tx_bit_q    <= SYNC_BYTE[7];
                        hold_q      <= s_data;
                        hold_vld_q  <= 1'b1;
                        crc_q       <= CRC8_INIT;
`else
                        state_q     <= DATA;
                        shift_q     <= {s_data[6:0], 1'b0};
                        tx_bit_q    <= s_data[7];
                        crc_q       <= crc8_step(CRC8_INIT, s_data[7]);
`endif
                    end
                end

`ifdef CRC8_TX_SYNC_EN
                SYNC,
`endif
                DATA: begin
                    if (accept && !bnd) begin
                        hold_q     <= s_data;
                        hold_vld_q <= 1'b1;
                    end
                    if (tick && !bnd) begin
                        bitcnt_q <= bitcnt_q + 3'd1;
                        shift_q  <= {shift_q[6:0], 1'b0};
                        tx_bit_q <= shift_q[7];
                        if (state_q == DATA) crc_q <= crc8_step(crc_q, shift_q[7]);
                    end else if (bnd) begin
                        bitcnt_q <= '0;
                        if (hold_vld_q) begin
                            state_q    <= DATA;
                            shift_q    <= {hold_q[6:0], 1'b0};
                            tx_bit_q   <= hold_q[7];
                            crc_q      <= crc8_step(crc_q, hold_q[7]);
                            hold_vld_q <= 1'b0;
                        end else if (accept) begin
                            state_q  <= DATA;
                            shift_q  <= {s_data[6:0], 1'b0};
                            tx_bit_q <= s_data[7];
                            crc_q    <= crc8_step(crc_q, s_data[7]);
                        end else begin
                            // Missing byte closes the frame with the CRC of what was sent.
                            state_q    <= CRC;
                            shift_q    <= {crc_q[6:0], 1'b0};
                            tx_bit_q   <= crc_q[7];
                            underrun_q <= !last_seen_q;
                        end
                    end
                end

                CRC: begin
                    if (tick && !bnd) begin
                        bitcnt_q <= bitcnt_q + 3'd1;
                        shift_q  <= {shift_q[6:0], 1'b0};
                        tx_bit_q <= shift_q[7];
                    end else if (bnd) begin
                        state_q      <= GAP;
                        bitcnt_q     <= '0;
                        gapcnt_q     <= '0;
                        tx_bit_q     <= 1'b0;
                        tx_active_q  <= 1'b0;
                        frame_done_q <= 1'b1;
                    end
                end

                GAP: begin
                    if (tick) begin
                        if (gapcnt_q == GAP_LAST) begin
                            state_q     <= IDLE;
                            last_seen_q <= 1'b0;
                            hold_vld_q  <= 1'b0;
                        end else begin
                            gapcnt_q <= gapcnt_q + GW'(1);
                        end
                    end
                end

                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc8_serial_tx.sv
// Bench for crc8_serial_tx: scoreboard of expected line bytes, one task per scenario.
`timescale 1ns/1ps
module tb_crc8_serial_tx;

`ifdef CRC8_TX_SYNC_EN
    localparam int SYNC_N = 1;
`else
    localparam int SYNC_N = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic [7:0] s_data, s_data4;
    logic       s_valid, s_last, s_valid4, s_last4;
    logic       s_ready, tx_bit, tx_active, frame_done, underrun;
    logic       s_ready4, tx_bit4, tx_active4, frame_done4, underrun4;

    crc8_serial_tx #(.CLKS_PER_BIT(1), .GAP_BITS(2)) dut (
        .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .tx_bit(tx_bit), .tx_active(tx_active),
        .frame_done(frame_done), .underrun(underrun));

    crc8_serial_tx #(.CLKS_PER_BIT(4), .GAP_BITS(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .s_data(s_data4), .s_valid(s_valid4), .s_last(s_last4),
        .s_ready(s_ready4), .tx_bit(tx_bit4), .tx_active(tx_active4),
        .frame_done(frame_done4), .underrun(underrun4));

    int n_chk = 0, n_fail = 0;
    logic [7:0] exp_q[$], exp4_q[$], rx_q[$];
    int act1, act4, done1, done4, urun1, urun4, hold_bad4;
    logic [7:0] sh1, sh4;
    int nb1, c4;
    logic cur4;

    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c;
        for (int i = 7; i >= 0; i--)
            r = {r[6:0], 1'b0} ^ ((r[7] ^ d[i]) ? 8'h07 : 8'h00);
        return r;
    endfunction

    // Expected line bytes for one frame, pushed as the stimulus is issued.
    task automatic push_frame(input int sel, input logic [7:0] b[$]);
        logic [7:0] c;
        c = 8'h00;
        if (SYNC_N != 0) begin
            if (sel != 0) exp4_q.push_back(8'hA5); else exp_q.push_back(8'hA5);
        end
        foreach (b[i]) begin
            c = crc8_byte(c, b[i]);
            if (sel != 0) exp4_q.push_back(b[i]); else exp_q.push_back(b[i]);
        end
        if (sel != 0) exp4_q.push_back(c); else exp_q.push_back(c);
    endtask

    // Line monitor, 1 clock per bit.
    always @(negedge clk) begin
        if (frame_done) done1++;
        if (underrun) urun1++;
        if (!rst_n) begin
            nb1 = 0;
        end else if (tx_active) begin
            sh1 = {sh1[6:0], tx_bit};
            nb1++;
            act1++;
            if (nb1 == 8) begin
                logic [7:0] e;
                nb1 = 0;
                rx_q.push_back(sh1);
                n_chk++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL line_byte: got %02h, none expected", sh1);
                end else begin
                    e = exp_q.pop_front();
                    if (sh1 !== e) begin
                        n_fail++;
                        $display("FAIL line_byte: got %02h expected %02h", sh1, e);
                    end
                end
            end
        end
    end

    // Line monitor, 4 clocks per bit; every clock of a bit must carry the same value.
    always @(negedge clk) begin
        if (frame_done4) done4++;
        if (underrun4) urun4++;
        if (!rst_n) begin
            c4 = 0;
        end else if (tx_active4) begin
            if (c4 % 4 == 0) begin
                cur4 = tx_bit4;
                sh4 = {sh4[6:0], tx_bit4};
            end else if (tx_bit4 !== cur4) begin
                hold_bad4++;
            end
            c4++;
            act4++;
            if (c4 == 32) begin
                logic [7:0] e;
                c4 = 0;
                n_chk++;
                if (exp4_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL line_byte4: got %02h, none expected", sh4);
                end else begin
                    e = exp4_q.pop_front();
                    if (sh4 !== e) begin
                        n_fail++;
                        $display("FAIL line_byte4: got %02h expected %02h", sh4, e);
                    end
                end
            end
        end
    end

    task automatic clear_counts();
        act1 = 0; act4 = 0; done1 = 0; done4 = 0; urun1 = 0; urun4 = 0; hold_bad4 = 0;
        rx_q.delete();
    endtask

    // Present one byte and return 1ns after the edge that accepts it.
    task automatic drive_byte(input int sel, input logic [7:0] d, input logic l);
        int t;
        t = 0;
        if (sel != 0) begin s_data4 = d; s_valid4 = 1'b1; s_last4 = l; end
        else begin s_data = d; s_valid = 1'b1; s_last = l; end
        while (!((sel != 0) ? s_ready4 : s_ready) && t < 200) begin
            @(posedge clk); #1; t++;
        end
        if (t >= 200) begin
            n_chk++; n_fail++;
            $display("FAIL drive_timeout: s_ready never high for byte %02h", d);
        end
        @(posedge clk); #1;
        if (sel != 0) begin s_valid4 = 1'b0; s_last4 = 1'b0; end
        else begin s_valid = 1'b0; s_last = 1'b0; end
    endtask

    // Wait for frame_done, then count clocks until s_ready returns; -1 on timeout.
    task automatic wait_end(input int sel, output int gap);
        int t;
        t = 0;
        gap = -1;
        @(negedge clk);
        while (!((sel != 0) ? frame_done4 : frame_done) && t < 2000) begin
            @(negedge clk); t++;
        end
        if (t >= 2000) return;
        gap = 0;
        while (!((sel != 0) ? s_ready4 : s_ready) && gap < 100) begin
            gap++; @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        s_valid = 0; s_last = 0; s_data = 0;
        s_valid4 = 0; s_last4 = 0; s_data4 = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++;
        if ({tx_bit, tx_active, frame_done, underrun, s_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00001", {tx_bit, tx_active, frame_done, underrun, s_ready});
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_01();
        int gap;
        clear_counts();
        push_frame(0, '{8'h01});
        drive_byte(0, 8'h01, 1'b1);
        wait_end(0, gap);
        n_chk++;
        if (gap !== 2) begin n_fail++; $display("FAIL gap_1clk: got %0d expected 2", gap); end
        n_chk++;
        if (done1 !== 1) begin n_fail++; $display("FAIL frame_done_01: got %0d pulses expected 1", done1); end
        n_chk++;
        if (urun1 !== 0) begin n_fail++; $display("FAIL underrun_01: got %0d pulses expected 0", urun1); end
    endtask

    task automatic test_ff_00();
        int gap;
        logic [7:0] pat[2];
        pat[0] = 8'hFF; pat[1] = 8'h00;
        for (int k = 0; k < 2; k++) begin
            clear_counts();
            push_frame(0, '{pat[k]});
            drive_byte(0, pat[k], 1'b1);
            wait_end(0, gap);
            n_chk++;
            if (act1 !== 16 + 8 * SYNC_N) begin
                n_fail++; $display("FAIL active_len_%02h: got %0d expected %0d", pat[k], act1, 16 + 8 * SYNC_N);
            end
            n_chk++;
            if (rx_q.size() == 0 || rx_q[rx_q.size()-1] !== ((k == 0) ? 8'hF3 : 8'h00)) begin
                n_fail++; $display("FAIL crc_%02h: got %p", pat[k], rx_q);
            end
        end
    endtask

    task automatic test_back_to_back();
        int gap;
        logic [7:0] b[$];
        logic [7:0] rem;
        clear_counts();
        for (int i = 0; i < 9; i++) b.push_back(8'h31 + 8'(i));
        push_frame(0, b);
        for (int i = 0; i < 9; i++) drive_byte(0, b[i], i == 8);
        n_chk++;
        if (s_ready !== 1'b0) begin n_fail++; $display("FAIL ready_after_last: got %b expected 0", s_ready); end
        wait_end(0, gap);
        n_chk++;
        if (act1 !== 80 + 8 * SYNC_N) begin
            n_fail++; $display("FAIL b2b_contiguous: got %0d active clocks expected %0d", act1, 80 + 8 * SYNC_N);
        end
        rem = 8'h00;
        for (int i = SYNC_N; i < rx_q.size(); i++) rem = crc8_byte(rem, rx_q[i]);
        n_chk++;
        if (rx_q.size() != 10 + SYNC_N || rx_q[rx_q.size()-1] !== 8'hF4 || rem !== 8'h00) begin
            n_fail++; $display("FAIL check_123456789: crc/remainder got %p rem %02h expected crc F4 rem 00", rx_q, rem);
        end
        n_chk++;
        if (urun1 !== 0 || done1 !== 1) begin
            n_fail++; $display("FAIL b2b_pulses: underrun %0d done %0d expected 0 1", urun1, done1);
        end
    endtask

    task automatic test_boundary_accept();
        int gap;
        clear_counts();
        push_frame(0, '{8'hA0, 8'h3C});
        drive_byte(0, 8'hA0, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        drive_byte(0, 8'h3C, 1'b1);
        wait_end(0, gap);
        n_chk++;
        if (urun1 !== 0 || act1 !== 24 + 8 * SYNC_N) begin
            n_fail++; $display("FAIL boundary_accept: underrun %0d active %0d expected 0 %0d", urun1, act1, 24 + 8 * SYNC_N);
        end
    endtask

    task automatic test_underrun();
        int gap;
        clear_counts();
        push_frame(0, '{8'h5A});
        drive_byte(0, 8'h5A, 1'b0);
        wait_end(0, gap);
        n_chk++;
        if (urun1 !== 1) begin n_fail++; $display("FAIL underrun_pulse: got %0d expected 1", urun1); end
        n_chk++;
        if (done1 !== 1 || gap !== 2) begin
            n_fail++; $display("FAIL underrun_close: done %0d gap %0d expected 1 2", done1, gap);
        end
    endtask

    task automatic test_slow_bits();
        int gap;
        clear_counts();
        push_frame(1, '{8'hC3});
        drive_byte(1, 8'hC3, 1'b1);
        wait_end(1, gap);
        n_chk++;
        if (gap !== 8) begin n_fail++; $display("FAIL gap_4clk: got %0d expected 8", gap); end
        n_chk++;
        if (act4 !== 64 + 32 * SYNC_N || hold_bad4 !== 0) begin
            n_fail++; $display("FAIL bit_period_4: active %0d bad holds %0d expected %0d 0", act4, hold_bad4, 64 + 32 * SYNC_N);
        end
        n_chk++;
        if (done4 !== 1 || urun4 !== 0) begin
            n_fail++; $display("FAIL pulses_4clk: done %0d underrun %0d expected 1 0", done4, urun4);
        end
    endtask

    task automatic test_reset_mid_frame();
        int gap;
        clear_counts();
        drive_byte(0, 8'hFF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        n_chk++;
        if (tx_active !== 1'b1) begin n_fail++; $display("FAIL pre_abort_active: got %b expected 1", tx_active); end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({tx_bit, tx_active, frame_done, underrun, s_ready} !== 5'b00001) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b expected 00001", {tx_bit, tx_active, frame_done, underrun, s_ready});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        n_chk++;
        if (done1 !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", done1); end
        clear_counts();
        push_frame(0, '{8'h01});
        drive_byte(0, 8'h01, 1'b1);
        wait_end(0, gap);
        n_chk++;
        if (rx_q.size() == 0 || rx_q[rx_q.size()-1] !== 8'h07) begin
            n_fail++; $display("FAIL crc_after_abort: got %p expected last byte 07", rx_q);
        end
        n_chk++;
        if (exp_q.size() != 0 || exp4_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain: %0d/%0d bytes never seen, expected 0", exp_q.size(), exp4_q.size());
        end
    endtask

    initial begin
        clear_counts();
        sh1 = 0; sh4 = 0; nb1 = 0; c4 = 0; cur4 = 0;
        test_reset();
        test_single_01();
        test_ff_00();
        test_back_to_back();
        test_boundary_accept();
        test_underrun();
        test_slow_bits();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
